// File: rtl/uart_mem_bridge_pkg.sv
// Shared command/response codes and state encodings for the uart memory bridge.
package uart_mem_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWrite,
    StRead,
    StRlatch,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxWait,
    TxArm,
    TxDrain
  } tx_state_e;

endpackage

// File: rtl/uart_mem_bridge_resp_tx.sv
// Response sender: takes up to DATA_WIDTH/8 bytes (MSB first) and feeds them to the uart
// transmitter one at a time using the start/busy handshake, then pulses done.
module uart_mem_bridge_resp_tx
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0]      load_count,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  done
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;

  logic [DATA_WIDTH-1:0] src;
  logic [CNT_W-1:0]      src_rem;
  logic                  issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TxIdle;
      sh_q       <= '0;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done       = 1'b0;
    src        = sh_q;
    src_rem    = rem_q;
    issue      = 1'b0;

    unique case (state_q)
      TxIdle: begin
        if (load) begin
          // A fresh load can go straight out if the uart is free, saving a cycle.
          src     = load_data;
          src_rem = load_count;
          sh_d    = load_data;
          rem_d   = load_count;
          state_d = TxWait;
          issue   = !tx_busy;
        end
      end
      TxWait: issue = !tx_busy;
      // The uart raises busy only a cycle after seeing start, so busy is ignored here.
      TxArm: state_d = TxDrain;
      TxDrain: begin
        if (!tx_busy) begin
          if (rem_q == '0) begin
            done    = 1'b1;
            state_d = TxIdle;
          end else begin
            issue = 1'b1;
          end
        end
      end
    endcase

    if (issue) begin
      tx_data_d  = src[DATA_WIDTH-1 -: 8];
      sh_d       = src << 8;
      rem_d      = src_rem - CNT_W'(1);
      tx_start_d = 1'b1;
      state_d    = TxArm;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// Host-packet parser: turns uart rx bytes into single-word memory writes/reads and
// returns ACK/NAK or read data through the uart transmitter.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_re,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  overrun
);

  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned BC_W       = $clog2(MAX_BYTES + 1);
  localparam int unsigned CNT_W      = $clog2(DATA_BYTES + 1);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  rx_re_q;
  logic [BC_W-1:0]       bcnt_q, bcnt_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  overrun_q, overrun_d;

  logic                  byte_evt;
  logic                  in_pkt;
  logic                  expire;
  logic                  busy_state;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CNT_W-1:0]      load_count;
  logic                  done;

  assign byte_evt   = rx_re & ~rx_re_q;
  assign in_pkt     = (state_q == StAddr) || (state_q == StData);
  assign expire     = in_pkt && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign busy_state = (state_q == StWrite) || (state_q == StRead) ||
                      (state_q == StRlatch) || (state_q == StResp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rx_re_q    <= 1'b0;
      bcnt_q     <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tmo_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_re_q    <= rx_re;
      bcnt_q     <= bcnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tmo_q      <= tmo_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    overrun_d  = overrun_q;
    load       = 1'b0;
    load_data  = '0;
    load_count = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    tmo_d      = (byte_evt || !in_pkt) ? '0 : tmo_q + TMO_W'(1);

    case (state_q)
      StIdle: begin
        if (byte_evt) begin
          bcnt_d = '0;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_write_d = (rx_data == CMD_WRITE);
            state_d    = StAddr;
          end else begin
            load       = 1'b1;
            load_data  = DATA_WIDTH'(RSP_NAK) << (DATA_WIDTH - 8);
            load_count = CNT_W'(1);
            state_d    = StResp;
          end
        end
      end
      StAddr: begin
        // Timeout takes priority over a coincident byte, which is then dropped.
        if (expire) begin
          overrun_d = 1'b1;
          state_d   = StIdle;
        end else if (byte_evt) begin
          addr_d = ADDR_WIDTH'({addr_q, rx_data});
          if (bcnt_q == BC_W'(ADDR_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = is_write_q ? StData : StRead;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      StData: begin
        if (expire) begin
          overrun_d = 1'b1;
          state_d   = StIdle;
        end else if (byte_evt) begin
          wdata_d = DATA_WIDTH'({wdata_q, rx_data});
          if (bcnt_q == BC_W'(DATA_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = StWrite;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      StWrite: begin
        mem_we     = 1'b1;
        load       = 1'b1;
        load_data  = DATA_WIDTH'(RSP_ACK) << (DATA_WIDTH - 8);
        load_count = CNT_W'(1);
        state_d    = StResp;
      end
      StRead: begin
        mem_re  = 1'b1;
        state_d = StRlatch;
      end
      StRlatch: begin
        load       = 1'b1;
        load_data  = mem_rdata;
        load_count = CNT_W'(DATA_BYTES);
        state_d    = StResp;
      end
      StResp: begin
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (byte_evt && busy_state) overrun_d = 1'b1;
  end

  uart_mem_bridge_resp_tx #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_resp_tx (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .done       (done)
  );

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign overrun   = overrun_q;

endmodule
